// File: rtl/ps2_device_emulator.sv
// PS/2 device-side link emulator.
// Generates the PS/2 clock, sends device->host bytes (start, D0..D7, odd parity, stop)
// and receives host->device command bytes including the ack bit.
// The lines are open-drain: the outputs are pulldown enables, the inputs are raw line levels.
// All line timing advances on an internal 1 us tick derived from main_clk.
module ps2_device_emulator #(
    parameter int unsigned TICK_DIV  = 90,
    parameter int unsigned HALF_US   = 40,
    parameter int unsigned IDLE_US   = 50,
    parameter int unsigned SETTLE_US = 5,
    parameter int unsigned REQ_US    = 100
) (
    input  logic       main_clk,
    input  logic       reset,
    output logic       external_clock_pulldown,
    output logic       external_data_pulldown,
    input  logic       external_clock_in,
    input  logic       external_data_in,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    output logic       busy
);

    localparam logic [6:0] TICK_LAST  = 7'(TICK_DIV - 1);
    localparam logic [7:0] HALF_LAST  = 8'(HALF_US - 1);
    localparam logic [7:0] MID_LAST   = 8'(HALF_US / 2 - 1);
    localparam logic [7:0] SETTLE_CNT = 8'(SETTLE_US);
    localparam logic [7:0] IDLE_CNT   = 8'(IDLE_US);
    localparam logic [7:0] REQ_LAST   = 8'(REQ_US - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_TX_HI,
        S_TX_LO,
        S_DONE_TX,
        S_ABORT,
        S_HOST_REQ,
        S_RX_LO,
        S_RX_HI,
        S_RX_ACK
    } state_t;

    state_t      state_q;
    logic [6:0]  tick_cnt_q;
    logic        tick;
    logic [1:0]  clk_sync_q;
    logic [1:0]  data_sync_q;
    logic        clock_in;
    logic        data_in;
    logic [7:0]  phase_q;
    logic [7:0]  phase_d;
    logic [7:0]  idle_cnt_q;
    logic [7:0]  idle_cnt_d;
    logic [3:0]  bit_idx_q;
    logic [7:0]  hold_q;
    logic        hold_valid_q;
    logic        tx_ready_q;
    logic [9:0]  rx_sh_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        rx_error_q;
    logic        clk_pd_q;
    logic        data_pd_q;
    logic [10:0] tx_frame;
    logic        tx_bit;

    assign clock_in = clk_sync_q[1];
    assign data_in  = data_sync_q[1];
    assign tick     = (tick_cnt_q == TICK_LAST);

    assign external_clock_pulldown = clk_pd_q;
    assign external_data_pulldown  = data_pd_q;
    assign tx_ready                = tx_ready_q;
    assign rx_data                 = rx_data_q;
    assign rx_valid                = rx_valid_q;
    assign rx_error                = rx_error_q;
    assign busy                    = (state_q != S_IDLE);

    // 1 us tick divider, wraps at TICK_DIV-1
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 7'd1;
        end
    end

    // Two-flop synchronizers for the raw line levels (lines idle high)
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], external_clock_in};
            data_sync_q <= {data_sync_q[0], external_data_in};
        end
    end

    // Saturating increments and the bit currently being sent
    always_comb begin
        phase_d    = (phase_q == 8'hFF) ? phase_q : phase_q + 8'd1;
        idle_cnt_d = (idle_cnt_q == 8'hFF) ? idle_cnt_q : idle_cnt_q + 8'd1;
        tx_frame   = {1'b1, ~^hold_q, hold_q, 1'b0};
        tx_bit     = tx_frame[bit_idx_q];
    end

    // Link FSM, holding register and registered outputs
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            phase_q      <= '0;
            idle_cnt_q   <= '0;
            bit_idx_q    <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            tx_ready_q   <= 1'b1;
            rx_sh_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_error_q   <= 1'b0;
            clk_pd_q     <= 1'b0;
            data_pd_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (tx_valid && tx_ready_q) begin
                hold_q       <= tx_data;
                hold_valid_q <= 1'b1;
                tx_ready_q   <= 1'b0;
            end
            if (tick) begin
                case (state_q)
                    S_IDLE: begin
                        clk_pd_q  <= 1'b0;
                        data_pd_q <= 1'b0;
                        if (clock_in && data_in) begin
                            idle_cnt_q <= idle_cnt_d;
                        end else begin
                            idle_cnt_q <= '0;
                        end
                        // Host request has priority: a held-low clock also blocks a TX start
                        if (!clock_in) begin
                            if (phase_q >= REQ_LAST) begin
                                state_q <= S_HOST_REQ;
                                phase_q <= '0;
                            end else begin
                                phase_q <= phase_d;
                            end
                        end else begin
                            phase_q <= '0;
                            if (hold_valid_q && data_in && idle_cnt_q >= IDLE_CNT) begin
                                state_q   <= S_TX_HI;
                                bit_idx_q <= '0;
                            end
                        end
                    end
                    S_TX_HI: begin
                        if (!clock_in && phase_q >= SETTLE_CNT) begin
                            state_q   <= S_ABORT;
                            clk_pd_q  <= 1'b0;
                            data_pd_q <= 1'b0;
                            phase_q   <= '0;
                        end else begin
                            phase_q <= phase_d;
                            if (phase_q == MID_LAST) begin
                                data_pd_q <= ~tx_bit;
                            end
                            if (phase_q == HALF_LAST) begin
                                state_q  <= S_TX_LO;
                                clk_pd_q <= 1'b1;
                                phase_q  <= '0;
                            end
                        end
                    end
                    S_TX_LO: begin
                        phase_q <= phase_d;
                        if (phase_q == HALF_LAST) begin
                            clk_pd_q <= 1'b0;
                            phase_q  <= '0;
                            if (bit_idx_q == 4'd10) begin
                                state_q <= S_DONE_TX;
                            end else begin
                                bit_idx_q <= bit_idx_q + 4'd1;
                                state_q   <= S_TX_HI;
                            end
                        end
                    end
                    S_DONE_TX: begin
                        data_pd_q    <= 1'b0;
                        hold_valid_q <= 1'b0;
                        tx_ready_q   <= 1'b1;
                        idle_cnt_q   <= '0;
                        phase_q      <= '0;
                        state_q      <= S_IDLE;
                    end
                    S_ABORT: begin
                        clk_pd_q   <= 1'b0;
                        data_pd_q  <= 1'b0;
                        bit_idx_q  <= '0;
                        idle_cnt_q <= '0;
                        phase_q    <= '0;
                        state_q    <= S_IDLE;
                    end
                    S_HOST_REQ: begin
                        if (clock_in) begin
                            phase_q <= '0;
                            if (!data_in) begin
                                state_q   <= S_RX_LO;
                                clk_pd_q  <= 1'b1;
                                bit_idx_q <= '0;
                            end else begin
                                idle_cnt_q <= '0;
                                state_q    <= S_IDLE;
                            end
                        end
                    end
                    S_RX_LO: begin
                        phase_q <= phase_d;
                        if (phase_q == HALF_LAST) begin
                            clk_pd_q <= 1'b0;
                            phase_q  <= '0;
                            state_q  <= S_RX_HI;
                        end
                    end
                    S_RX_HI: begin
                        if (!clock_in && phase_q >= SETTLE_CNT) begin
                            idle_cnt_q <= '0;
                            phase_q    <= '0;
                            state_q    <= S_IDLE;
                        end else begin
                            phase_q <= phase_d;
                            if (phase_q == MID_LAST) begin
                                rx_sh_q[bit_idx_q] <= data_in;
                            end
                            if (phase_q == HALF_LAST) begin
                                phase_q  <= '0;
                                clk_pd_q <= 1'b1;
                                if (bit_idx_q == 4'd9) begin
                                    data_pd_q <= 1'b1;
                                    state_q   <= S_RX_ACK;
                                end else begin
                                    bit_idx_q <= bit_idx_q + 4'd1;
                                    state_q   <= S_RX_LO;
                                end
                            end
                        end
                    end
                    S_RX_ACK: begin
                        phase_q <= phase_d;
                        if (phase_q == HALF_LAST) begin
                            clk_pd_q   <= 1'b0;
                            data_pd_q  <= 1'b0;
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_sh_q[7:0];
                            rx_error_q <= ~(^rx_sh_q[8:0]) | ~rx_sh_q[9];
                            idle_cnt_q <= '0;
                            phase_q    <= '0;
                            state_q    <= S_IDLE;
                        end
                    end
                    default: begin
                        clk_pd_q  <= 1'b0;
                        data_pd_q <= 1'b0;
                        phase_q   <= '0;
                        state_q   <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_device_emulator.sv
// Directed bench for ps2_device_emulator: models the PS/2 host on a wired-AND line pair.
module tb_ps2_device_emulator;

    localparam int TD       = 4;
    localparam int HALF     = 40;
    localparam int IDLE     = 50;
    localparam int SETTLE   = 5;
    localparam int REQ      = 100;
    localparam int HALF_CYC = HALF * TD;

    logic       main_clk = 1'b0;
    logic       reset = 1'b1;
    logic       dut_clk_pd, dut_data_pd;
    logic       host_clk_pd = 1'b0, host_data_pd = 1'b0;
    logic       clk_line, data_line;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_error, busy;

    int n_vec = 0;
    int n_bad = 0;
    int rxv_cnt = 0;
    logic [7:0] rx_last = '0;
    logic       rxe_last = 1'b0;

    assign clk_line  = !(dut_clk_pd || host_clk_pd);
    assign data_line = !(dut_data_pd || host_data_pd);

    always #5 main_clk = ~main_clk;

    ps2_device_emulator #(
        .TICK_DIV (TD),
        .HALF_US  (HALF),
        .IDLE_US  (IDLE),
        .SETTLE_US(SETTLE),
        .REQ_US   (REQ)
    ) dut (
        .main_clk               (main_clk),
        .reset                  (reset),
        .external_clock_pulldown(dut_clk_pd),
        .external_data_pulldown (dut_data_pd),
        .external_clock_in      (clk_line),
        .external_data_in       (data_line),
        .tx_data                (tx_data),
        .tx_valid               (tx_valid),
        .tx_ready               (tx_ready),
        .rx_data                (rx_data),
        .rx_valid               (rx_valid),
        .rx_error               (rx_error),
        .busy                   (busy)
    );

    // Capture every rx_valid cycle
    always @(negedge main_clk) begin
        if (rx_valid) begin
            rxv_cnt  <= rxv_cnt + 1;
            rx_last  <= rx_data;
            rxe_last <= rx_error;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        @(negedge main_clk);
        chk("tx_ready_before", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge main_clk);
        #1 tx_valid = 1'b0;
        @(negedge main_clk);
        chk("tx_ready_drop", tx_ready, 0);
    endtask

    // Host receiving a device frame: data sampled at each clock fall
    task automatic host_recv(input int budget, output logic [10:0] fr, output int nf,
                             output int lmin, output int lmax, output int first);
        int cyc = 0;
        int lstart = 0;
        logic prev, cur;
        fr = '0; nf = 0; lmin = 99999; lmax = 0; first = -1;
        prev = clk_line;
        while (cyc < budget && !(nf == 11 && prev)) begin
            @(negedge main_clk);
            cyc++;
            cur = clk_line;
            if (prev && !cur) begin
                if (nf < 11) fr[nf] = data_line;
                if (nf == 0) first = cyc;
                nf++;
                lstart = cyc;
            end else if (!prev && cur && nf > 0) begin
                if (cyc - lstart < lmin) lmin = cyc - lstart;
                if (cyc - lstart > lmax) lmax = cyc - lstart;
            end
            prev = cur;
        end
    endtask

    // Host request-to-send followed by 10 bits driven at device clock falls
    task automatic host_send(input logic [7:0] b, input logic p, input logic s,
                             output int nf, output logic ack);
        logic [9:0] fr;
        int cyc = 0;
        logic prev, cur, done;
        fr = {s, p, b};
        nf = 0; ack = 1'b0; done = 1'b0;
        host_clk_pd = 1'b1;
        repeat ((REQ / 2) * TD) @(negedge main_clk);
        host_data_pd = 1'b1;
        repeat ((REQ / 2 + 10) * TD) @(negedge main_clk);
        host_clk_pd = 1'b0;
        prev = 1'b1;
        while (!done && cyc < 1500 * TD) begin
            @(negedge main_clk);
            cyc++;
            cur = clk_line;
            if (prev && !cur) begin
                nf++;
                if (nf <= 10) begin
                    host_data_pd = !fr[nf-1];
                end else begin
                    host_data_pd = 1'b0;
                    repeat (20) @(negedge main_clk);
                    cyc += 20;
                    ack = !data_line;
                    cur = clk_line;
                end
            end else if (!prev && cur && nf == 11) begin
                done = 1'b1;
            end
            prev = cur;
        end
        host_data_pd = 1'b0;
    endtask

    task automatic wait_falls(input int target, input int budget, output int nf);
        int cyc = 0;
        logic prev, cur;
        nf = 0;
        prev = clk_line;
        while (nf < target && cyc < budget) begin
            @(negedge main_clk);
            cyc++;
            cur = clk_line;
            if (prev && !cur) nf++;
            prev = cur;
        end
    endtask

    task automatic wait_clk_high(input int budget, output logic ok);
        int cyc = 0;
        ok = clk_line;
        while (!ok && cyc < budget) begin
            @(negedge main_clk);
            cyc++;
            ok = clk_line;
        end
    endtask

    task automatic wait_tx_ready(input int budget, output logic ok);
        int cyc = 0;
        ok = tx_ready;
        while (!ok && cyc < budget) begin
            @(negedge main_clk);
            cyc++;
            ok = tx_ready;
        end
    endtask

    initial begin
        logic [10:0] fr;
        int nf, lmin, lmax, first, rx0;
        logic ack, ok, rel;

        // Reset state
        repeat (3) @(negedge main_clk);
        chk("rst_clk_pd", dut_clk_pd, 0);
        chk("rst_data_pd", dut_data_pd, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_error", rx_error, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        // 1: device sends 0x1C to an idle host
        push_tx(8'h1C);
        host_recv(1200 * TD, fr, nf, lmin, lmax, first);
        chk("t1_nfall", nf, 11);
        chk("t1_frame", fr, 11'h438);
        chk("t1_low_min", lmin, HALF_CYC);
        chk("t1_low_max", lmax, HALF_CYC);
        wait_tx_ready(10 * TD, ok);
        chk("t1_tx_ready", ok, 1);
        repeat (3 * TD) @(negedge main_clk);
        chk("t1_busy", busy, 0);

        // 2: host sends 0xFF with correct parity
        rx0 = rxv_cnt;
        host_send(8'hFF, 1'b1, 1'b1, nf, ack);
        repeat (10) @(negedge main_clk);
        chk("t2_nclk", nf, 11);
        chk("t2_ack", ack, 1);
        chk("t2_rx_pulses", rxv_cnt - rx0, 1);
        chk("t2_rx_data", rx_last, 8'hFF);
        chk("t2_rx_error", rxe_last, 0);
        chk("t2_rx_data_hold", rx_data, 8'hFF);

        // 3: host sends 0xED with wrong (even) parity
        rx0 = rxv_cnt;
        host_send(8'hED, 1'b0, 1'b1, nf, ack);
        repeat (10) @(negedge main_clk);
        chk("t3_ack", ack, 1);
        chk("t3_rx_pulses", rxv_cnt - rx0, 1);
        chk("t3_rx_data", rx_last, 8'hED);
        chk("t3_rx_error", rxe_last, 1);

        // 3b: stop bit 0 with good parity
        rx0 = rxv_cnt;
        host_send(8'h00, 1'b1, 1'b0, nf, ack);
        repeat (10) @(negedge main_clk);
        chk("t3b_ack", ack, 1);
        chk("t3b_rx_pulses", rxv_cnt - rx0, 1);
        chk("t3b_rx_error", rxe_last, 1);

        // 4: host inhibits during the high phase after D5 of 0xAA
        repeat (10 * TD) @(negedge main_clk);
        push_tx(8'hAA);
        wait_falls(7, 1200 * TD, nf);
        chk("t4_falls", nf, 7);
        wait_clk_high(HALF_CYC + 20, ok);
        chk("t4_high", ok, 1);
        repeat (25 * TD) @(negedge main_clk);
        chk("t4_d6_driven", dut_data_pd, 1);
        host_clk_pd = 1'b1;
        rel = 1'b0;
        for (int i = 0; i < TD + 4 && !rel; i++) begin
            @(negedge main_clk);
            rel = !dut_clk_pd && !dut_data_pd;
        end
        chk("t4_released", rel, 1);
        chk("t4_tx_ready", tx_ready, 0);
        repeat (60 * TD) @(negedge main_clk);
        host_clk_pd = 1'b0;
        host_recv(1200 * TD, fr, nf, lmin, lmax, first);
        chk("t4_nfall", nf, 11);
        chk("t4_frame", fr, 11'h754);
        chk("t4_gap", first >= (IDLE + HALF) * TD, 1);
        wait_tx_ready(10 * TD, ok);
        chk("t4_tx_ready_end", ok, 1);

        // 5: reset mid clock-low phase
        push_tx(8'h33);
        wait_falls(3, 1200 * TD, nf);
        repeat (10 * TD) @(negedge main_clk);
        chk("t5_clk_low", dut_clk_pd, 1);
        reset = 1'b1;
        #1;
        chk("t5_clk_pd", dut_clk_pd, 0);
        chk("t5_data_pd", dut_data_pd, 0);
        chk("t5_tx_ready", tx_ready, 1);
        chk("t5_busy", busy, 0);
        @(negedge main_clk);
        reset = 1'b0;
        wait_falls(1, 300 * TD, nf);
        chk("t5_no_resume", nf, 0);

        // 6: host request and a queued byte at the same time
        host_clk_pd = 1'b1;
        repeat (3) @(negedge main_clk);
        push_tx(8'h5A);
        rx0 = rxv_cnt;
        host_send(8'hF0, 1'b1, 1'b1, nf, ack);
        repeat (10) @(negedge main_clk);
        chk("t6_ack", ack, 1);
        chk("t6_rx_first", rxv_cnt - rx0, 1);
        chk("t6_rx_data", rx_last, 8'hF0);
        chk("t6_rx_error", rxe_last, 0);
        host_recv(1200 * TD, fr, nf, lmin, lmax, first);
        chk("t6_nfall", nf, 11);
        chk("t6_frame", fr, 11'h6B4);
        wait_tx_ready(10 * TD, ok);
        chk("t6_tx_ready", ok, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
